alu_rr_scheduler: RTL and testbench
===================================

Name: alu_rr_scheduler

Overview:
Round-robin scheduler that shares one 4-bit combinational ALU (add/sub/and/or, op 00/01/10/11) among NREQ requesters. It accepts one operation at a time, drives the ALU from registered operands, and captures the result. It returns the result with the winner's ID over a valid/ready response channel. It sits between requester logic and the single ALU instance.

Parameters:
NREQ, 4, number of requesters (2..8)
W, 4, operand/result width; must equal ALU width
IDW, 2, requester ID width; equals clog2(NREQ)

Ports:
clk  in  1  rising-edge clock
rst  in  1  synchronous active-high reset
req_valid  in  NREQ  per-requester operation request
req_ready  out  NREQ  per-requester grant/accept, at most one bit high
req_a  in  NREQ*W  packed A operands, requester i at bits [i*W +: W]
req_b  in  NREQ*W  packed B operands, same packing
req_op  in  NREQ*2  packed opcodes, requester i at bits [i*2 +: 2]
alu_a  out  W  operand A to ALU
alu_b  out  W  operand B to ALU
alu_op  out  2  opcode to ALU
alu_result  in  W  ALU combinational result
rsp_valid  out  1  response valid
rsp_ready  in  1  response consumer ready
rsp_data  out  W  captured ALU result
rsp_id  out  IDW  index of the requester served
op_count  out  8  completed responses, wraps 255->0
busy  out  1  high whenever state != IDLE

Behaviour:
- One clock, clk. Reset is synchronous and active-high on rst.
- Reset, taking priority over everything:
  - state=IDLE; rr pointer=0.
  - alu_a, alu_b, alu_op, rsp_data, rsp_id, op_count all 0.
  - rsp_valid=0; req_ready all 0.
- An in-flight operation is discarded on reset and is not counted.
- FSM states: IDLE, ISSUE, RESP.
- IDLE:
  - If any req_valid is set, the winner is the first set bit searching from the pointer upward, wrapping modulo NREQ.
  - req_ready[winner]=1 combinationally in the same cycle; it is 0 in all other states and for all other bits.
  - On that edge: latch the winner's a, b and op into alu_a, alu_b and alu_op; latch the winner into rsp_id; go to ISSUE.
  - No req_valid set: stay in IDLE, with no register changes.
- ISSUE (exactly 1 cycle): ALU inputs are stable. On the edge, rsp_data<=alu_result, rsp_valid<=1, go to RESP.
- RESP:
  - rsp_valid, rsp_data and rsp_id are held stable until rsp_ready=1.
  - On the handshake edge: rsp_valid<=0; pointer<=(rsp_id+1) mod NREQ; op_count<=op_count+1 (8-bit wrap); go to IDLE.
- Latency: request accepted at edge T, rsp_valid high after edge T+1. With rsp_ready held high, the response completes at edge T+2 and the next grant comes at the earliest at edge T+3, so there is at most one operation per 3 cycles.
- alu_a, alu_b and alu_op hold their last latched values in all states; they change only on a grant edge.
- Requester protocol: a requester holds req_valid and its operands until it sees req_ready. Dropping req_valid before a grant is legal; that requester is simply skipped.
- Requests arriving during ISSUE or RESP wait; there is no queueing beyond the held req_valid.
- Arithmetic is the ALU's: W-bit modulo, no carry/borrow out. The scheduler never modifies results.
- The pointer advances only on a completed response, which guarantees fairness: every continuously asserting requester is served within NREQ grants.
- Unused IDW bits: none, since NREQ is a power of two by default. For non-power-of-two NREQ the pointer wraps at NREQ-1.

Test Plan:
1. Single request: after reset, requester 2 asserts a=4'h9, b=4'h8, op=00; rsp_ready=1 -> req_ready=4'b0100 one cycle; rsp_valid one cycle later with rsp_data=4'h1, rsp_id=2; op_count=1.
2. Contention: all four req_valid held high with op=01, a=4'h3, b=i, rsp_ready=1 -> grants in order 0,1,2,3,0; rsp_data=4'h3,4'h2,4'h1,4'h0,4'h3; grants spaced 3 cycles apart.
3. Backpressure: requester 1, a=4'hC, b=4'hA, op=10; rsp_ready=0 for 5 cycles -> rsp_valid, rsp_data=4'h8 and rsp_id=1 stable throughout; no grant to requester 3 (asserting meanwhile) until the cycle after rsp_ready rises.
4. Reset mid-operation: assert rst during RESP (rsp_data=4'hE from op=11, a=4'hC, b=4'h6) -> next cycle rsp_valid=0, state IDLE, op_count unchanged-from-reset (0), pointer 0.
5. op_count wrap: 256 back-to-back completions from requester 0 -> op_count reads 255 then 0; busy low only in IDLE cycles.
6. Withdrawn request: requester 1 pulses req_valid while busy and drops it before RESP ends; requester 3 holds req_valid -> next grant goes to 3; requester 1 is never granted.

Source files
------------

// File: rtl/alu_rr_scheduler_if.sv
// alu_rr_scheduler_if: request and response handshake bundle between requesters and the scheduler
interface alu_rr_scheduler_if #(
  parameter int NREQ = 4,
  parameter int W = 4,
  parameter int IDW = 2
);
  logic [NREQ-1:0] req_valid;
  logic [NREQ-1:0] req_ready;
  logic [NREQ*W-1:0] req_a;
  logic [NREQ*W-1:0] req_b;
  logic [NREQ*2-1:0] req_op;
  logic rsp_valid;
  logic rsp_ready;
  logic [W-1:0] rsp_data;
  logic [IDW-1:0] rsp_id;
  modport master (
    output req_valid, req_a, req_b, req_op, rsp_ready,
    input req_ready, rsp_valid, rsp_data, rsp_id
  );
  modport slave (
    input req_valid, req_a, req_b, req_op, rsp_ready,
    output req_ready, rsp_valid, rsp_data, rsp_id
  );
endinterface

// File: rtl/alu_rr_scheduler.sv
// alu_rr_scheduler: round-robin sharing of one combinational ALU among NREQ requesters
module alu_rr_scheduler #(
  parameter int NREQ = 4,
  parameter int W = 4,
  parameter int IDW = 2
) (
  input  logic clk,
  input  logic rst,
  alu_rr_scheduler_if.slave bus,
  output logic [W-1:0] alu_a,
  output logic [W-1:0] alu_b,
  output logic [1:0] alu_op,
  input  logic [W-1:0] alu_result,
  output logic [7:0] op_count,
  output logic busy
);
  typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;
  state_t state, state_n;
  logic [IDW-1:0] ptr, off, win;
  logic [IDW:0] sum;
  logic [2*NREQ-1:0] dbl;
  logic [NREQ-1:0] rot;
  logic found;
  // rotate requests so bit 0 is the pointer position; lowest set bit wins
  assign dbl = {bus.req_valid, bus.req_valid} >> ptr;
  assign rot = dbl[NREQ-1:0];
  always_comb begin
    found = 1'b0;
    off = '0;
    for (int k = NREQ - 1; k >= 0; k--)
      if (rot[k]) begin
        found = 1'b1;
        off = IDW'(k);
      end
  end
  assign sum = {1'b0, ptr} + {1'b0, off};
  assign win = (sum >= (IDW+1)'(NREQ)) ? IDW'(sum - (IDW+1)'(NREQ)) : IDW'(sum);
  assign bus.req_ready = (state == IDLE && found) ? (NREQ'(1) << win) : '0;
  assign busy = state != IDLE;
  always_comb begin
    state_n = state;
    state_n = (state == IDLE) ? (found ? ISSUE : IDLE) :
              (state == ISSUE) ? RESP : (bus.rsp_ready ? IDLE : RESP);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      ptr <= '0;
      alu_a <= '0;
      alu_b <= '0;
      alu_op <= '0;
      bus.rsp_data <= '0;
      bus.rsp_id <= '0;
      bus.rsp_valid <= 1'b0;
      op_count <= '0;
    end else begin
      state <= state_n;
      if (state == IDLE && found) begin
        alu_a <= bus.req_a[win*W +: W];
        alu_b <= bus.req_b[win*W +: W];
        alu_op <= bus.req_op[win*2 +: 2];
        bus.rsp_id <= win;
      end
      if (state == ISSUE) begin
        bus.rsp_data <= alu_result;
        bus.rsp_valid <= 1'b1;
      end
      if (state == RESP && bus.rsp_ready) begin
        bus.rsp_valid <= 1'b0;
        ptr <= (bus.rsp_id == IDW'(NREQ - 1)) ? '0 : bus.rsp_id + 1'b1;
        op_count <= op_count + 8'd1;
      end
    end
  end
endmodule

// File: tb/tb_alu_rr_scheduler.sv
// tb_alu_rr_scheduler: directed stimulus, per-cycle check against a transaction-level model
module tb_alu_rr_scheduler;
  localparam int N = 4;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [3:0] alu_a, alu_b, alu_result;
  logic [1:0] alu_op;
  logic [7:0] op_count;
  logic busy;
  always #5 clk = ~clk;
  alu_rr_scheduler_if #(.NREQ(4), .W(4), .IDW(2)) bus();
  alu_rr_scheduler #(.NREQ(4), .W(4), .IDW(2)) dut (
    .clk(clk), .rst(rst), .bus(bus),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_result(alu_result),
    .op_count(op_count), .busy(busy)
  );
  function automatic logic [3:0] alu(input logic [3:0] a, input logic [3:0] b, input logic [1:0] op);
    return op == 2'd0 ? a + b : op == 2'd1 ? a - b : op == 2'd2 ? (a & b) : (a | b);
  endfunction
  assign alu_result = alu(alu_a, alu_b, alu_op);
  int vecs = 0, errs = 0;
  task automatic chk(input string nm, input int act, input int exp);
    vecs++;
    if (act != exp) begin
      errs++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask
  function automatic int winner(input logic [3:0] v, input int p);
    for (int k = 0; k < N; k++)
      if (v[(p + k) % N]) return (p + k) % N;
    return -1;
  endfunction
  // transaction-level model: phase 0 waiting, 1 computing, 2 offering response
  int ph = 0, mptr = 0, mcnt = 0, mid = 0, mdata = 0, mvalid = 0, mw = 0;
  logic [3:0] ma = 0, mb = 0;
  logic [1:0] mop = 0;
  always @(posedge clk) begin
    mw = winner(bus.req_valid, mptr);
    if (rst) begin
      ph = 0; mptr = 0; mcnt = 0; mid = 0; mdata = 0; mvalid = 0; ma = 0; mb = 0; mop = 0;
    end else if (ph == 0) begin
      if (mw >= 0) begin
        ma = bus.req_a[mw*4 +: 4];
        mb = bus.req_b[mw*4 +: 4];
        mop = bus.req_op[mw*2 +: 2];
        mid = mw;
        ph = 1;
      end
    end else if (ph == 1) begin
      mdata = int'(alu(ma, mb, mop));
      mvalid = 1;
      ph = 2;
    end else if (bus.rsp_ready) begin
      mvalid = 0;
      mptr = (mid + 1) % N;
      mcnt = (mcnt + 1) % 256;
      ph = 0;
    end
  end
  int gq[$], gt[$], dq[$];
  int cyc = 0, cw = 0, gi = 0;
  always @(negedge clk) begin
    cw = winner(bus.req_valid, mptr);
    chk("req_ready", int'(bus.req_ready), (ph == 0 && cw >= 0) ? (1 << cw) : 0);
    chk("alu_a", int'(alu_a), int'(ma));
    chk("alu_b", int'(alu_b), int'(mb));
    chk("alu_op", int'(alu_op), int'(mop));
    chk("rsp_valid", int'(bus.rsp_valid), mvalid);
    chk("rsp_data", int'(bus.rsp_data), mdata);
    chk("rsp_id", int'(bus.rsp_id), mid);
    chk("op_count", int'(op_count), mcnt);
    chk("busy", int'(busy), int'(ph != 0));
    if (bus.req_ready != 0) begin
      gi = -1;
      for (int i = 0; i < N; i++) if (bus.req_ready[i]) gi = i;
      gq.push_back(gi);
      gt.push_back(cyc);
    end
    if (bus.rsp_valid && bus.rsp_ready) dq.push_back(int'(bus.rsp_data));
    cyc++;
  end
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic set_req(input int i, input logic [3:0] a, input logic [3:0] b, input logic [1:0] op);
    bus.req_a[i*4 +: 4] = a;
    bus.req_b[i*4 +: 4] = b;
    bus.req_op[i*2 +: 2] = op;
    bus.req_valid[i] = 1'b1;
  endtask
  task automatic do_reset();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    gq.delete();
    gt.delete();
    dq.delete();
  endtask
  int ge[5] = '{0, 1, 2, 3, 0};
  int de[5] = '{3, 2, 1, 0, 3};
  initial begin
    bus.req_valid = '0;
    bus.req_a = '0;
    bus.req_b = '0;
    bus.req_op = '0;
    bus.rsp_ready = 1'b1;
    do_reset();
    @(negedge clk);
    chk("reset op_count", int'(op_count), 0);
    chk("reset busy", int'(busy), 0);
    chk("reset rsp_valid", int'(bus.rsp_valid), 0);
    // single request from requester 2: 9 + 8 wraps to 1
    step();
    set_req(2, 4'h9, 4'h8, 2'd0);
    @(negedge clk);
    chk("t1 ready", int'(bus.req_ready), 4);
    step();
    bus.req_valid = '0;
    @(negedge clk);
    chk("t1 issue busy", int'(busy), 1);
    step();
    @(negedge clk);
    chk("t1 rsp_valid", int'(bus.rsp_valid), 1);
    chk("t1 rsp_data", int'(bus.rsp_data), 1);
    chk("t1 rsp_id", int'(bus.rsp_id), 2);
    step();
    @(negedge clk);
    chk("t1 op_count", int'(op_count), 1);
    chk("t1 idle", int'(busy), 0);
    // contention: all four subtract i from 3
    step();
    do_reset();
    for (int i = 0; i < N; i++) set_req(i, 4'h3, 4'(i), 2'd1);
    repeat (15) step();
    bus.req_valid = '0;
    chk("t2 grants", gq.size(), 5);
    for (int i = 0; i < 5; i++) begin
      chk("t2 grant order", i < gq.size() ? gq[i] : -1, ge[i]);
      chk("t2 rsp data", i < dq.size() ? dq[i] : -1, de[i]);
    end
    for (int i = 1; i < 5; i++) chk("t2 spacing", i < gt.size() ? gt[i] - gt[i-1] : -1, 3);
    // backpressure: C & A = 8 held while requester 3 waits
    bus.rsp_ready = 1'b0;
    set_req(1, 4'hC, 4'hA, 2'd2);
    @(negedge clk);
    chk("t3 ready", int'(bus.req_ready), 2);
    step();
    bus.req_valid = '0;
    set_req(3, 4'h1, 4'h1, 2'd0);
    step();
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("t3 hold valid", int'(bus.rsp_valid), 1);
      chk("t3 hold data", int'(bus.rsp_data), 8);
      chk("t3 hold id", int'(bus.rsp_id), 1);
      chk("t3 no grant", int'(bus.req_ready), 0);
      step();
    end
    bus.rsp_ready = 1'b1;
    @(negedge clk);
    chk("t3 no grant at handshake", int'(bus.req_ready), 0);
    step();
    @(negedge clk);
    chk("t3 grant 3", int'(bus.req_ready), 8);
    step();
    bus.req_valid = '0;
    step();
    step();
    @(negedge clk);
    chk("t3 op_count", int'(op_count), 7);
    // reset while the response C | 6 = E is pending
    step();
    bus.rsp_ready = 1'b0;
    set_req(2, 4'hC, 4'h6, 2'd3);
    step();
    bus.req_valid = '0;
    step();
    @(negedge clk);
    chk("t4 rsp_valid", int'(bus.rsp_valid), 1);
    chk("t4 rsp_data", int'(bus.rsp_data), 14);
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    @(negedge clk);
    chk("t4 rsp_valid cleared", int'(bus.rsp_valid), 0);
    chk("t4 idle", int'(busy), 0);
    chk("t4 op_count", int'(op_count), 0);
    step();
    bus.rsp_ready = 1'b1;
    set_req(1, 4'h2, 4'h3, 2'd0);
    set_req(3, 4'h2, 4'h3, 2'd0);
    @(negedge clk);
    chk("t4 ptr reset", int'(bus.req_ready), 2);
    step();
    bus.req_valid = '0;
    step();
    step();
    // 256 completions from requester 0
    do_reset();
    set_req(0, 4'h5, 4'h7, 2'd0);
    repeat (765) step();
    @(negedge clk);
    chk("t5 op_count 255", int'(op_count), 255);
    repeat (3) step();
    bus.req_valid = '0;
    @(negedge clk);
    chk("t5 op_count wrap", int'(op_count), 0);
    // requester 1 withdraws before it can be granted
    step();
    gq.delete();
    set_req(0, 4'h1, 4'h2, 2'd3);
    step();
    bus.req_valid = '0;
    set_req(1, 4'h4, 4'h4, 2'd0);
    set_req(3, 4'h6, 4'h1, 2'd1);
    step();
    bus.req_valid[1] = 1'b0;
    step();
    @(negedge clk);
    chk("t6 grant 3", int'(bus.req_ready), 8);
    step();
    bus.req_valid = '0;
    repeat (3) step();
    chk("t6 grants", gq.size(), 2);
    chk("t6 first", gq.size() > 0 ? gq[0] : -1, 0);
    chk("t6 second", gq.size() > 1 ? gq[1] : -1, 3);
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
